// File: rtl/mem_line_ctrl.sv
// Line transfer engine between the cache controller and the external memory port:
// optional write-back of one dirty line, then optional fill of one line, word by word.
module mem_line_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned OFF_W       = $clog2(BLOCK_WORDS)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_start,
  input  logic                  i_writeback,
  input  logic                  i_fill,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [ADDR_WIDTH-1:0] i_fill_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic [OFF_W-1:0]      o_word_idx,
  output logic                  o_fill_we,
  output logic [DATA_WIDTH-1:0] o_fill_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_read_request,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_successful_access
);

  localparam int unsigned LINE_W = ADDR_WIDTH - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;
  logic [LINE_W-1:0] fill_line_q, fill_line_d;
  logic              fill_q, fill_d;
  logic              last_word;

  // Word-offset and byte bits of the incoming addresses are replaced by idx.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_wb_addr[OFF_W+1:0], i_fill_addr[OFF_W+1:0]};

  assign last_word = &idx_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wb_line_d   = wb_line_q;
    fill_line_d = fill_line_q;
    fill_d      = fill_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          wb_line_d   = i_wb_addr[ADDR_WIDTH-1:OFF_W+2];
          fill_line_d = i_fill_addr[ADDR_WIDTH-1:OFF_W+2];
          fill_d      = i_fill;
          idx_d       = '0;
          if (i_writeback)  state_d = WRITE;
          else if (i_fill)  state_d = READ;
          else              state_d = DONE;
        end
      end
      WRITE: begin
        if (i_mem_successful_access) begin
          idx_d = idx_q + 1'b1;
          if (last_word) begin
            idx_d   = '0;
            state_d = fill_q ? READ : DONE;
          end
        end
      end
      READ: begin
        if (i_mem_successful_access) begin
          idx_d = idx_q + 1'b1;
          if (last_word) begin
            idx_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wb_line_q   <= '0;
      fill_line_q <= '0;
      fill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wb_line_q   <= wb_line_d;
      fill_line_q <= fill_line_d;
      fill_q      <= fill_d;
    end
  end

  // Control outputs decode the state register; data paths stay combinational.
  always_comb begin
    o_busy             = (state_q != IDLE);
    o_done             = (state_q == DONE);
    o_word_idx         = idx_q;
    o_mem_write_en     = (state_q == WRITE);
    o_mem_read_request = (state_q == READ);
    o_mem_addr         = '0;
    o_mem_data         = '0;
    o_fill_we          = 1'b0;
    o_fill_data        = '0;
    case (state_q)
      WRITE: begin
        o_mem_addr = {wb_line_q, idx_q, 2'b00};
        o_mem_data = i_wb_data;
      end
      READ: begin
        o_mem_addr = {fill_line_q, idx_q, 2'b00};
        o_fill_we  = i_mem_successful_access;
        if (i_mem_successful_access) o_fill_data = i_mem_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Scoreboard bench for mem_line_ctrl: a latency-randomised memory responder,
// a line-level reference model pushing expected transfers, and a decoupled monitor.
module tb_mem_line_ctrl;
  localparam int BW = 16;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        i_start = 1'b0, i_writeback = 1'b0, i_fill = 1'b0;
  logic [31:0] i_wb_addr = '0, i_fill_addr = '0;
  logic [31:0] i_wb_data;
  logic [3:0]  o_word_idx;
  logic        o_fill_we, o_busy, o_done, o_mem_read_request, o_mem_write_en;
  logic [31:0] o_fill_data, o_mem_addr, o_mem_data;
  logic [31:0] i_mem_data = '0;
  logic        i_mem_successful_access = 1'b0;

  mem_line_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .arst(arst), .i_start(i_start), .i_writeback(i_writeback), .i_fill(i_fill),
    .i_wb_addr(i_wb_addr), .i_fill_addr(i_fill_addr), .i_wb_data(i_wb_data),
    .o_word_idx(o_word_idx), .o_fill_we(o_fill_we), .o_fill_data(o_fill_data),
    .o_busy(o_busy), .o_done(o_done), .o_mem_read_request(o_mem_read_request),
    .o_mem_write_en(o_mem_write_en), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data), .i_mem_successful_access(i_mem_successful_access)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- cache side: dirty line presented by word index
  logic [31:0] wb_line [BW];
  assign i_wb_data = wb_line[o_word_idx];

  // ---------------- memory responder (environment)
  function automatic logic [31:0] mem_init(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  logic [31:0] dev_mem [logic [31:0]];
  function automatic logic [31:0] dev_read(input logic [31:0] wa);
    return dev_mem.exists(wa) ? dev_mem[wa] : mem_init(wa);
  endfunction

  logic [7:0] lfsr = 8'h15;
  bit resp_en = 1'b1;
  int wait_mode = 0;   // <0: LFSR-random 0..3 wait cycles per word
  int wait_left = 0;
  bit wait_set = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        if (i_mem_successful_access) begin
          i_mem_successful_access = 1'b0;
          i_mem_data = '0;
          wait_set = 1'b0;
        end
        if (o_mem_read_request || o_mem_write_en) begin
          if (!wait_set) begin
            if (wait_mode < 0) begin
              lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
              wait_left = int'(lfsr[1:0]);
            end else wait_left = wait_mode;
            wait_set = 1'b1;
          end
          if (wait_left == 0) begin
            i_mem_successful_access = 1'b1;
            if (o_mem_read_request) i_mem_data = dev_read(o_mem_addr >> 2);
          end else wait_left--;
        end else wait_set = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && !arst && i_mem_successful_access && o_mem_write_en)
        dev_mem[o_mem_addr >> 2] = o_mem_data;
    end
  end

  // ---------------- reference model + scoreboard
  typedef enum int {K_WR, K_RD, K_DONE} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_read(input logic [31:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : mem_init(wa);
  endfunction

  task automatic push_exp(input bit wb, input bit fl, input logic [31:0] wa, input logic [31:0] fa);
    logic [31:0] wbase, fbase;
    exp_t e;
    wbase = {wa[31:6], 6'b0};
    fbase = {fa[31:6], 6'b0};
    for (int i = 0; i < BW; i++) wb_line[i] = $urandom();
    if (wb)
      for (int i = 0; i < BW; i++) begin
        e.kind = K_WR; e.addr = wbase + 32'(4 * i); e.data = wb_line[i];
        sb.push_back(e);
        ref_mem[e.addr >> 2] = e.data;
      end
    if (fl)
      for (int i = 0; i < BW; i++) begin
        e.kind = K_RD; e.addr = fbase + 32'(4 * i); e.data = ref_read(e.addr >> 2);
        sb.push_back(e);
      end
    e.kind = K_DONE; e.addr = '0; e.data = '0;
    sb.push_back(e);
  endtask

  // ---------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!arst) begin
        if (o_mem_read_request || o_mem_write_en) begin
          total++;
          if (o_mem_read_request && o_mem_write_en) begin
            bad++;
            $display("FAIL req_exclusive actual rd=1 wr=1 required not both (cycle %0d)", cyc);
          end
        end
        if (o_fill_we && !(o_mem_read_request && i_mem_successful_access)) begin
          total++; bad++;
          $display("FAIL stray_fill_we actual=1 required=0 (cycle %0d)", cyc);
        end
        if (i_mem_successful_access && (o_mem_read_request || o_mem_write_en)) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_access actual addr=0x%08h required none (cycle %0d)", o_mem_addr, cyc);
          end else begin
            e = sb.pop_front();
            if (e.kind == K_WR) begin
              chk("wr_en", 32'(o_mem_write_en), 32'd1);
              chk("wr_addr", o_mem_addr, e.addr);
              chk("wr_data", o_mem_data, e.data);
            end else if (e.kind == K_RD) begin
              chk("rd_req", 32'(o_mem_read_request), 32'd1);
              chk("rd_addr", o_mem_addr, e.addr);
              chk("fill_we", 32'(o_fill_we), 32'd1);
              chk("fill_data", o_fill_data, e.data);
            end else begin
              total++; bad++;
              $display("FAIL order actual=access required=done (cycle %0d)", cyc);
            end
            chk("word_idx", 32'(o_word_idx), 32'(e.addr[5:2]));
          end
        end
        if (o_done) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("done_order", 32'(e.kind), 32'(K_DONE));
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic issue(input bit wb, input bit fl, input logic [31:0] wa, input logic [31:0] fa,
                       input bit hold, output int start_cyc);
    @(posedge clk); #1;
    i_start = 1'b1; i_writeback = wb; i_fill = fl; i_wb_addr = wa; i_fill_addr = fa;
    start_cyc = cyc;
    if (!hold) begin
      @(posedge clk); #1;
      i_start = 1'b0; i_writeback = $urandom(); i_fill = $urandom();
      i_wb_addr = $urandom(); i_fill_addr = $urandom();
    end
  endtask

  task automatic wait_done(input string name, output int done_cyc, output int first_req);
    first_req = -1; done_cyc = -1;
    for (int n = 0; n < 3000 && done_cyc < 0; n++) begin
      @(negedge clk);
      if (first_req < 0 && (o_mem_read_request || o_mem_write_en)) first_req = cyc;
      if (o_done) done_cyc = cyc;
    end
    if (done_cyc < 0) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=no done required=done within 3000 cycles", name);
    end
  endtask

  task automatic run_cmd(input string name, input bit wb, input bit fl, input logic [31:0] wa,
                         input logic [31:0] fa, output int s, output int d, output int f);
    push_exp(wb, fl, wa, fa);
    issue(wb, fl, wa, fa, 1'b0, s);
    wait_done(name, d, f);
    @(posedge clk); #1;
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(o_busy), 32'd0);
    chk({name, "_done"}, 32'(o_done), 32'd0);
    chk({name, "_fill_we"}, 32'(o_fill_we), 32'd0);
    chk({name, "_rd"}, 32'(o_mem_read_request), 32'd0);
    chk({name, "_wr"}, 32'(o_mem_write_en), 32'd0);
    chk({name, "_addr"}, o_mem_addr, 32'd0);
    chk({name, "_mdata"}, o_mem_data, 32'd0);
    chk({name, "_fdata"}, o_fill_data, 32'd0);
    chk({name, "_idx"}, 32'(o_word_idx), 32'd0);
  endtask

  // ---------------- test sequence
  initial begin
    int s, d, f, busy_cnt, done_cnt;
    for (int i = 0; i < BW; i++) wb_line[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; arst = 1'b0;

    // Fill only, zero-wait, memory holds 0xA0+idx
    wait_mode = 0;
    for (int i = 0; i < BW; i++) begin
      dev_mem[(32'h140 >> 2) + 32'(i)] = 32'hA0 + 32'(i);
      ref_mem[(32'h140 >> 2) + 32'(i)] = 32'hA0 + 32'(i);
    end
    run_cmd("fill", 1'b0, 1'b1, 32'h0, 32'h0000_0140, s, d, f);
    chk("fill_first_req", 32'(f - s), 32'd1);
    chk("fill_done_cyc", 32'(d - s), 32'd17);

    // Write-back then fill, 3 wait cycles per word
    wait_mode = 3;
    run_cmd("wbfill", 1'b1, 1'b1, 32'h200, 32'h400, s, d, f);
    chk("wbfill_done_lat", 32'(d - f), 32'd128);

    // Flush only, unaligned address forced to line base
    wait_mode = 0;
    run_cmd("flush", 1'b1, 1'b0, 32'h37, 32'h800, s, d, f);
    chk("flush_done_cyc", 32'(d - s), 32'd17);

    // Null command
    run_cmd("null", 1'b0, 1'b0, 32'h1234, 32'h5678, s, d, f);
    total++;
    if (d - s < 1 || d - s > 2) begin
      bad++;
      $display("FAIL null_done_cyc actual=%0d required=1..2", d - s);
    end

    // Start held high through busy and DONE: exactly one operation
    wait_mode = 1;
    push_exp(1'b0, 1'b1, 32'h0, 32'h0000_0C00);
    issue(1'b0, 1'b1, 32'h0, 32'h0000_0C00, 1'b1, s);
    wait_done("held", d, f);
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("held_sb_empty", 32'(sb.size()), 32'd0);
    busy_cnt = 0;
    repeat (30) begin @(negedge clk); if (o_busy) busy_cnt++; end
    chk("held_no_second_op", 32'(busy_cnt), 32'd0);

    // Reset at word 5 of a zero-wait fill, then a spurious strobe
    wait_mode = 0;
    push_exp(1'b0, 1'b1, 32'h0, 32'h0000_0E40);
    issue(1'b0, 1'b1, 32'h0, 32'h0000_0E40, 1'b0, s);
    repeat (5) @(posedge clk);
    #2;
    resp_en = 1'b0; wait_set = 1'b0;
    i_mem_successful_access = 1'b0; i_mem_data = '0;
    arst = 1'b1;
    chk("midrst_words_done", 32'(sb.size()), 32'(BW - 5 + 1));
    sb.delete();
    @(posedge clk); #2;
    arst = 1'b0;
    i_mem_successful_access = 1'b1; i_mem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #2;
    i_mem_successful_access = 1'b0; i_mem_data = '0;
    busy_cnt = 0; done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy || o_fill_we) busy_cnt++;
      if (o_done) done_cnt++;
    end
    chk("midrst_idle", 32'(busy_cnt), 32'd0);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    resp_en = 1'b1;

    // Random latency soak
    wait_mode = -1;
    for (int n = 0; n < 100; n++) begin
      logic [31:0] wa, fa;
      bit wb, fl;
      wb = $urandom(); fl = $urandom();
      wa = 32'h1000 + (32'($urandom_range(0, 7)) << 6) + 32'($urandom_range(0, 63));
      fa = 32'h1000 + (32'($urandom_range(0, 7)) << 6) + 32'($urandom_range(0, 63));
      run_cmd("soak", wb, fl, wa, fa, s, d, f);
    end
    foreach (ref_mem[k]) chk("mem_ref", dev_read(k), ref_mem[k]);
    foreach (dev_mem[k]) chk("mem_dev", dev_mem[k], ref_read(k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
